sweep_sequencer: RTL and testbench

- Controller that sequences the phase_step input of the sawtooth/sine/square waveform generators through a programmed frequency sweep.
- Sits between the control/UI logic and a generator instance; its phase_step output drives the generator's phase_step input directly.
- Steps from a start step toward a stop step by a fixed delta, holding each step for a programmed number of sample ticks.
- Supports one-shot, looping and ping-pong sweeps, with abort.

---
 rtl/sweep_sequencer.sv | 177 +++++++++++++++++
 tb/tb_sweep_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_sequencer.sv
// Frequency-sweep controller: walks phase_step from start toward stop in delta
// increments, dwelling a programmed number of sample ticks per step.
module sweep_sequencer #(
   parameter int STEP_W  = 32,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [STEP_W-1:0]  cfg_start,
   input  logic [STEP_W-1:0]  cfg_stop,
   input  logic [STEP_W-1:0]  cfg_delta,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [1:0]         cfg_mode,
   input  logic               abort,
   input  logic               sample_tick,
   output logic [STEP_W-1:0]  phase_step,
   output logic               gen_en,
   output logic               busy,
   output logic               done
);

   // Config handshake: a transfer happens in any cycle with cfg_valid && cfg_ready;
   // cfg_ready is only offered while idle and not aborting.

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [STEP_W-1:0]    phase_q, phase_d;
   logic [STEP_W-1:0]    start_q, start_d;
   logic [STEP_W-1:0]    stop_q, stop_d;
   logic [STEP_W-1:0]    delta_q, delta_d;
   logic [STEP_W-1:0]    target_q, target_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [1:0]           mode_q, mode_d;
   logic                 dir_q, dir_d;      // 1 = counting down
   logic                 done_q, done_d;

   logic                 accept;
   logic [DWELL_W-1:0]   dwell_eff;
   logic [STEP_W-1:0]    pong_target;

   // One step toward target, computed one bit wider so a carry or borrow
   // clamps to target instead of wrapping.
   function automatic logic [STEP_W-1:0] advance(
      input logic [STEP_W-1:0] cur,
      input logic [STEP_W-1:0] dlt,
      input logic              down,
      input logic [STEP_W-1:0] tgt
   );
      logic [STEP_W:0] wide;
      logic [STEP_W-1:0] res;
      res = tgt;
      if (dlt != '0) begin
         if (!down) begin
            wide = {1'b0, cur} + {1'b0, dlt};
            if (!wide[STEP_W] && (wide[STEP_W-1:0] <= tgt)) res = wide[STEP_W-1:0];
         end else begin
            wide = {1'b0, cur} - {1'b0, dlt};
            if (!wide[STEP_W] && (wide[STEP_W-1:0] >= tgt)) res = wide[STEP_W-1:0];
         end
      end
      return res;
   endfunction

   assign accept      = cfg_valid && cfg_ready;
   assign dwell_eff   = (dwell_q == '0) ? DWELL_ONE : dwell_q;
   assign pong_target = (target_q == stop_q) ? start_q : stop_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         start_q  <= '0;
         stop_q   <= '0;
         delta_q  <= '0;
         target_q <= '0;
         dwell_q  <= '0;
         cnt_q    <= '0;
         mode_q   <= '0;
         dir_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         start_q  <= start_d;
         stop_q   <= stop_d;
         delta_q  <= delta_d;
         target_q <= target_d;
         dwell_q  <= dwell_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         dir_q    <= dir_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      start_d  = start_q;
      stop_d   = stop_q;
      delta_d  = delta_q;
      target_d = target_q;
      dwell_d  = dwell_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      dir_d    = dir_q;
      done_d   = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  start_d  = cfg_start;
                  stop_d   = cfg_stop;
                  delta_d  = cfg_delta;
                  dwell_d  = cfg_dwell;
                  mode_d   = cfg_mode;
                  dir_d    = (cfg_stop < cfg_start);
                  target_d = cfg_stop;
                  phase_d  = cfg_start;
                  cnt_d    = (cfg_dwell == '0) ? DWELL_ONE : cfg_dwell;
                  state_d  = RUN;
               end
            end
            RUN: begin
               if (sample_tick) begin
                  if (cnt_q > DWELL_ONE) begin
                     cnt_d = cnt_q - DWELL_ONE;
                  end else begin
                     cnt_d = dwell_eff;
                     if (phase_q != target_q) begin
                        phase_d = advance(phase_q, delta_q, dir_q, target_q);
                     end else begin
                        unique case (mode_q)
                           2'd1: begin
                              phase_d  = start_q;
                              dir_d    = (stop_q < start_q);
                              target_d = stop_q;
                           end
                           2'd2: begin
                              dir_d    = ~dir_q;
                              target_d = pong_target;
                              phase_d  = advance(phase_q, delta_q, ~dir_q, pong_target);
                           end
                           default: begin
                              done_d  = 1'b1;
                              state_d = IDLE;
                           end
                        endcase
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cfg_ready  = (state_q == IDLE) && !abort;
      gen_en     = (state_q == RUN);
      busy       = (state_q != IDLE);
      done       = done_q;
      phase_step = phase_q;
   end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer: one-shot, saturation, ping-pong, loop,
// abort, handshake and reset scenarios with hand-computed expectations.
module tb_sweep_sequencer;

   logic        clk;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_start;
   logic [31:0] cfg_stop;
   logic [31:0] cfg_delta;
   logic [15:0] cfg_dwell;
   logic [1:0]  cfg_mode;
   logic        abort;
   logic        sample_tick;
   logic [31:0] phase_step;
   logic        gen_en;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] pp_exp [10];
   logic [31:0] lp_exp [6];

   sweep_sequencer #(.STEP_W(32), .DWELL_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_start   (cfg_start),
      .cfg_stop    (cfg_stop),
      .cfg_delta   (cfg_delta),
      .cfg_dwell   (cfg_dwell),
      .cfg_mode    (cfg_mode),
      .abort       (abort),
      .sample_tick (sample_tick),
      .phase_step  (phase_step),
      .gen_en      (gen_en),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
   endtask

   task automatic send_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] d,
                           input logic [15:0] w, input logic [1:0] m);
      cfg_start = s;
      cfg_stop  = e;
      cfg_delta = d;
      cfg_dwell = w;
      cfg_mode  = m;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      cfg_valid   = 1'b0;
      cfg_start   = '0;
      cfg_stop    = '0;
      cfg_delta   = '0;
      cfg_dwell   = '0;
      cfg_mode    = '0;
      abort       = 1'b0;
      sample_tick = 1'b0;
      pp_exp = '{32'd25, 32'd40, 32'd25, 32'd10, 32'd25, 32'd40, 32'd25, 32'd10, 32'd25, 32'd40};
      lp_exp = '{32'd30, 32'd20, 32'd50, 32'd30, 32'd20, 32'd50};

      // reset state
      gap(3);
      chk("rst_phase", phase_step, 32'h0);
      chk("rst_gen_en", {31'b0, gen_en}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      rst_n = 1'b1;
      gap(1);
      chk("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);

      // one-shot up, dwell 2, tick every 4 clocks
      send_cfg(32'h100, 32'h400, 32'h100, 16'd2, 2'd0);
      chk("os_first_phase", phase_step, 32'h100);
      chk("os_first_gen_en", {31'b0, gen_en}, 32'd1);
      chk("os_first_busy", {31'b0, busy}, 32'd1);
      chk("os_cfg_ready_busy", {31'b0, cfg_ready}, 32'd0);
      gap(8);
      chk("os_no_tick_hold", phase_step, 32'h100);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk($sformatf("os_phase_t%0d", k), phase_step, 32'h100 * (1 + k / 2));
         chk($sformatf("os_done_t%0d", k), {31'b0, done}, 32'd0);
         gap(3);
      end
      tick();
      chk("os_done_pulse", {31'b0, done}, 32'd1);
      chk("os_end_gen_en", {31'b0, gen_en}, 32'd0);
      chk("os_end_busy", {31'b0, busy}, 32'd0);
      chk("os_end_phase", phase_step, 32'h400);
      gap(1);
      chk("os_done_single", {31'b0, done}, 32'd0);
      chk("os_hold_phase", phase_step, 32'h400);

      // saturation near top of range: must clamp, not wrap
      gap(2);
      send_cfg(32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h80, 16'd1, 2'd0);
      chk("sat_p0", phase_step, 32'hFFFF_FF00);
      tick();
      chk("sat_p1", phase_step, 32'hFFFF_FF80);
      gap(2);
      tick();
      chk("sat_p2_clamp", phase_step, 32'hFFFF_FFF0);
      chk("sat_busy", {31'b0, busy}, 32'd1);
      gap(2);
      tick();
      chk("sat_done", {31'b0, done}, 32'd1);
      chk("sat_final", phase_step, 32'hFFFF_FFF0);

      // ping-pong
      gap(2);
      send_cfg(32'd10, 32'd40, 32'd15, 16'd1, 2'd2);
      chk("pp_p0", phase_step, 32'd10);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("pp_phase_%0d", k), phase_step, pp_exp[k]);
         chk($sformatf("pp_done_%0d", k), {31'b0, done}, 32'd0);
         chk($sformatf("pp_busy_%0d", k), {31'b0, busy}, 32'd1);
         gap(1);
      end
      do_abort();
      chk("pp_abort_busy", {31'b0, busy}, 32'd0);
      chk("pp_abort_phase", phase_step, 32'd40);

      // loop, down direction, dwell 0 acts as 1
      gap(2);
      send_cfg(32'd50, 32'd20, 32'd20, 16'd0, 2'd1);
      chk("lp_p0", phase_step, 32'd50);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("lp_phase_%0d", k), phase_step, lp_exp[k]);
         chk($sformatf("lp_busy_%0d", k), {31'b0, busy}, 32'd1);
      end
      do_abort();

      // start == stop one-shot: one dwell then done
      gap(2);
      send_cfg(32'd7, 32'd7, 32'd3, 16'd3, 2'd3);
      tick();
      tick();
      chk("eq_still_busy", {31'b0, busy}, 32'd1);
      chk("eq_phase", phase_step, 32'd7);
      tick();
      chk("eq_done", {31'b0, done}, 32'd1);
      chk("eq_idle", {31'b0, busy}, 32'd0);

      // abort mid-step
      gap(2);
      send_cfg(32'h100, 32'h400, 32'h100, 16'd2, 2'd0);
      tick();
      tick();
      chk("ab_pre_phase", phase_step, 32'h200);
      tick();
      do_abort();
      chk("ab_gen_en", {31'b0, gen_en}, 32'd0);
      chk("ab_busy", {31'b0, busy}, 32'd0);
      chk("ab_done", {31'b0, done}, 32'd0);
      chk("ab_phase", phase_step, 32'h200);
      gap(2);
      chk("ab_no_late_done", {31'b0, done}, 32'd0);

      // cfg_valid held while running is ignored
      send_cfg(32'd5, 32'd100, 32'd1, 16'd3, 2'd1);
      cfg_start = 32'h777;
      cfg_stop  = 32'h0;
      cfg_delta = 32'h50;
      cfg_dwell = 16'd1;
      cfg_mode  = 2'd0;
      cfg_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("hold_ready_%0d", k), {31'b0, cfg_ready}, 32'd0);
         tick();
      end
      chk("hold_phase", phase_step, 32'd6);
      chk("hold_busy", {31'b0, busy}, 32'd1);
      cfg_valid = 1'b0;
      do_abort();

      // abort + cfg_valid in idle: refused until abort drops
      cfg_start = 32'h33;
      cfg_stop  = 32'h33;
      cfg_delta = 32'h1;
      cfg_dwell = 16'd1;
      cfg_mode  = 2'd0;
      cfg_valid = 1'b1;
      abort     = 1'b1;
      #1;
      chk("ac_ready_low", {31'b0, cfg_ready}, 32'd0);
      @(negedge clk);
      chk("ac_not_accepted", {31'b0, busy}, 32'd0);
      abort = 1'b0;
      #1;
      chk("ac_ready_high", {31'b0, cfg_ready}, 32'd1);
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("ac_accepted", {31'b0, busy}, 32'd1);
      chk("ac_phase", phase_step, 32'h33);
      do_abort();

      // reset mid-sweep at phase 0x300
      send_cfg(32'h100, 32'h400, 32'h100, 16'd1, 2'd0);
      tick();
      tick();
      chk("mr_pre_phase", phase_step, 32'h300);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_phase", phase_step, 32'h0);
      chk("mr_gen_en", {31'b0, gen_en}, 32'd0);
      chk("mr_busy", {31'b0, busy}, 32'd0);
      chk("mr_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mr_cfg_ready", {31'b0, cfg_ready}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
